// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Widest supported data field; helpers take zero-extended data.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit a well-formed frame carries for the given data bits.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] bits,
                                      input parity_e mode);
    case (mode)
      PAR_ODD:  return ~^bits;
      PAR_EVEN: return ^bits;
      default:  return 1'b0;
    endcase
  endfunction

  // Two-out-of-three vote used to reject single-sample line noise.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read side of the receive FIFO: show-ahead head, valid/ready pop, occupancy.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int LEVEL_W   = 4
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic [LEVEL_W-1:0]   level;

  modport master (output data, output data_valid, output level, input data_ready);
  modport slave  (input data, input data_valid, input level, output data_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; a push is visible at the head the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  // Pop on empty is ignored; push on full is accepted only if the head leaves too.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero while empty so the output is defined out of reset.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Storage write.
  // NOTE: the array has no reset; only pointers and level need one, and a
  // reset here would turn the array into flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, frame checks, talk escape byte,
// receive FIFO and level-driven RTS.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 32,
  parameter int         DATA_BITS      = 8,
  parameter int         PARITY         = 0,
  parameter int         STOP_BITS      = 1,
  parameter int         FIFO_DEPTH     = 8,
  parameter int         RTS_HIGH_WATER = FIFO_DEPTH - 2,
  parameter int         IDLE_BITS      = 9,
  parameter logic [7:0] TALK_BYTE      = 8'hFE
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rx,
  output logic              rts,
  uart_rx_fifo_if.master    rd,
  output logic              talk,
  input  logic              talk_ack,
  output logic              framing_err,
  output logic              parity_err,
  output logic              overrun_err,
  input  logic              err_clr
);

  localparam int LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W       = $clog2(CLKS_PER_BIT);
  localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W      = $clog2(IDLE_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  S_EARLY   = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CNT_W-1:0]  S_MID     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  S_LATE    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [LW-1:0]     HIGH_WATER = LW'(RTS_HIGH_WATER);
  localparam parity_e           PAR_MODE  = parity_e'(PARITY[1:0]);

  // Escape value compared against the configured number of data LSBs.
  localparam logic [MAX_DATA_BITS-1:0] TALK_EXT = {1'b0, TALK_BYTE};
  localparam logic [DATA_BITS-1:0]     TALK_CMP = TALK_EXT[DATA_BITS-1:0];

  rx_state_e            state_q;
  logic                 sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDLE_W-1:0]    idle_cnt_q;
  logic [3:0]           bit_idx_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 bad_q;
  logic                 rts_q, talk_q, framing_q, parity_q, overrun_q;

  logic                 rx_s;
  logic                 vote, at_vote, at_end, last_stop, is_talk;
  logic                 frame_ok, push;
  logic                 fifo_full, fifo_empty, pop_fire;

  assign rx_s = sync2_q;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Bit-position strobes and the FIFO push decision for a completed frame.
  always_comb begin
    // NOTE: each combinational output gets a default first so no path can
    // leave one unassigned and infer a latch.
    vote      = majority3(samp_q[1], samp_q[0], rx_s);
    at_vote   = (cnt_q == S_LATE);
    at_end    = (cnt_q == '0);
    last_stop = (bit_idx_q == 4'(STOP_BITS - 1));
    is_talk   = (shreg_q == TALK_CMP);
    pop_fire  = rd.data_ready & ~fifo_empty;
    frame_ok  = 1'b0;
    push      = 1'b0;
    if (state_q == ST_STOP && at_vote && vote && last_stop) begin
      frame_ok = 1'b1;
      push     = ~bad_q & ~is_talk & (~fifo_full | pop_fire);
    end
  end

  // Receive FSM, sample capture, sticky flags and registered RTS.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_INIT;
      cnt_q      <= CNT_LOAD;
      idle_cnt_q <= '0;
      bit_idx_q  <= '0;
      samp_q     <= 2'b11;
      shreg_q    <= '0;
      bad_q      <= 1'b0;
      rts_q      <= 1'b1;
      talk_q     <= 1'b0;
      framing_q  <= 1'b0;
      parity_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // Free-running bit timer; reloaded at each boundary and on start detect.
      cnt_q <= at_end ? CNT_LOAD : cnt_q - 1'b1;
      if (cnt_q == S_EARLY) samp_q[1] <= rx_s;
      if (cnt_q == S_MID)   samp_q[0] <= rx_s;

      // Clears come first so a set later in this block wins in the same cycle.
      if (talk_ack) talk_q <= 1'b0;
      if (err_clr) begin
        framing_q <= 1'b0;
        parity_q  <= 1'b0;
        overrun_q <= 1'b0;
      end

      rts_q <= (state_q == ST_INIT) || (rd.level >= HIGH_WATER);

      case (state_q)
        ST_INIT: begin
          if (!rx_s) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= CNT_LOAD;
            bad_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state_q <= ST_IDLE;
          end else if (at_end) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (at_vote) shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              state_q   <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote && (vote != parity_bit(MAX_DATA_BITS'(shreg_q), PAR_MODE))) bad_q <= 1'b1;
          if (at_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (at_vote) begin
            if (!vote) begin
              framing_q  <= 1'b1;
              idle_cnt_q <= '0;
              state_q    <= ST_INIT;
            end else if (frame_ok) begin
              if (bad_q)                      parity_q  <= 1'b1;
              else if (is_talk)               talk_q    <= 1'b1;
              else if (fifo_full && !pop_fire) overrun_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (at_end) begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (push),
    .push_data_i (shreg_q),
    .pop_i       (rd.data_ready),
    .pop_data_o  (rd.data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (rd.level)
  );

  assign rd.data_valid = ~fifo_empty;
  assign rts           = rts_q;
  assign talk          = talk_q;
  assign framing_err   = framing_q;
  assign parity_err    = parity_q;
  assign overrun_err   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: default-format instance (a) and even-parity instance (b).
module tb_uart_rx_fifo;

  localparam int CPB = 32;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic talk_ack_a = 1'b0, talk_ack_b = 1'b0;
  logic err_clr_a = 1'b0, err_clr_b = 1'b0;
  logic rts_a, rts_b, talk_a, talk_b;
  logic fe_a, pe_a, oe_a, fe_b, pe_b, oe_b;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb [$];
  logic [7:0] sb_exp;

  uart_rx_fifo_if #(.DATA_BITS(8), .LEVEL_W(4)) rd_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .LEVEL_W(4)) rd_b ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .nrst(nrst), .rx(rx_a), .rts(rts_a), .rd(rd_a),
    .talk(talk_a), .talk_ack(talk_ack_a), .framing_err(fe_a),
    .parity_err(pe_a), .overrun_err(oe_a), .err_clr(err_clr_a)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_b (
    .clk(clk), .nrst(nrst), .rx(rx_b), .rts(rts_b), .rd(rd_b),
    .talk(talk_b), .talk_ack(talk_ack_b), .framing_err(fe_b),
    .parity_err(pe_b), .overrun_err(oe_b), .err_clr(err_clr_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every pop of instance a is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rd_a.data_valid && rd_a.data_ready) begin
      check("sb_avail", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        sb_exp = sb.pop_front();
        check("sb_data", rd_a.data, sb_exp);
      end
    end
  end

  // All line drives start 1 time unit after a rising edge.
  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic hold(input bit sel, input logic v, input int cycles);
    drive(sel, v);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Start bit, LSB-first data (optionally one-cycle inverted at mid-bit), optional parity.
  task automatic send_head(input bit sel, input logic [7:0] d, input bit with_par,
                           input logic par, input int glitch_bit);
    hold(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(sel, d[i], CPB / 2);
        hold(sel, ~d[i], 1);
        hold(sel, d[i], CPB / 2 - 1);
      end else begin
        hold(sel, d[i], CPB);
      end
    end
    if (with_par) hold(sel, par, CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop_v, input int glitch_bit);
    send_head(sel, d, with_par, par, glitch_bit);
    hold(sel, stop_v, CPB);
    drive(sel, 1'b1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (!rd_a.data_valid && t < 4 * CPB) begin
        @(posedge clk); #1;
        t++;
      end
      check("drain_valid", rd_a.data_valid, 1);
      rd_a.data_ready = 1'b1;
      @(posedge clk); #1;
      rd_a.data_ready = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    talk_ack_a = 1'b1;
    @(posedge clk); #1;
    talk_ack_a = 1'b0;
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) err_clr_b = 1'b1; else err_clr_a = 1'b1;
    @(posedge clk); #1;
    err_clr_a = 1'b0;
    err_clr_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp_level;
    rd_a.data_ready = 1'b0;
    rd_b.data_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rts", rts_a, 1);
    check("rst_valid", rd_a.data_valid, 0);
    check("rst_level", rd_a.level, 0);
    check("rst_data", rd_a.data, 0);
    check("rst_talk", talk_a, 0);
    check("rst_errs", {fe_a, pe_a, oe_a}, 3'b000);
    nrst = 1'b1;

    // Leave INIT: more than nine bit-times of idle line.
    repeat (10 * CPB) @(posedge clk);
    #1;
    check("init_done_rts", rts_a, 0);
    check("init_done_rts_b", rts_b, 0);

    // Plain byte.
    send_frame(0, 8'h41, 0, 0, 1, -1);
    sb.push_back(8'h41);
    check("t1_valid", rd_a.data_valid, 1);
    check("t1_data", rd_a.data, 8'h41);
    check("t1_level", rd_a.level, 1);
    drain(1);
    check("t1_popped", rd_a.data_valid, 0);

    // Talk escape byte is flagged, never queued.
    send_frame(0, 8'hFE, 0, 0, 1, -1);
    check("talk_set", talk_a, 1);
    check("talk_level", rd_a.level, 0);
    pulse_ack();
    check("talk_ack_clear", talk_a, 0);
    // Hold ack through the stop bit and drop it right after talk rises, so the
    // ack overlapped the setting cycle.
    send_head(0, 8'hFE, 0, 0, -1);
    talk_ack_a = 1'b1;
    drive(0, 1'b1);
    for (int i = 0; i < CPB; i++) begin
      @(posedge clk); #1;
      if (talk_a) talk_ack_a = 1'b0;
    end
    talk_ack_a = 1'b0;
    check("talk_set_wins", talk_a, 1);
    check("talk_level2", rd_a.level, 0);
    pulse_ack();

    // Even parity on instance b: 0x03 needs parity 0.
    send_frame(1, 8'h03, 1, 1, 1, -1);
    check("par_err", pe_b, 1);
    check("par_level", rd_b.level, 0);
    pulse_clr(1);
    check("par_clr", pe_b, 0);
    send_frame(1, 8'h03, 1, 0, 1, -1);
    check("par_ok_level", rd_b.level, 1);
    check("par_ok_data", rd_b.data, 8'h03);
    check("par_ok_errs", {fe_b, pe_b, oe_b}, 3'b000);
    rd_b.data_ready = 1'b1;
    @(posedge clk); #1;
    rd_b.data_ready = 1'b0;
    check("par_popped", rd_b.data_valid, 0);

    // Framing error, then INIT must see nine idle bit-times again.
    send_frame(0, 8'h55, 0, 0, 0, -1);
    check("frm_err", fe_a, 1);
    check("frm_level", rd_a.level, 0);
    check("frm_rts", rts_a, 1);
    pulse_clr(0);
    check("frm_clr", fe_a, 0);
    hold(0, 1'b1, 4 * CPB);
    send_frame(0, 8'h55, 0, 0, 1, -1);
    check("frm_early_ignored", rd_a.level, 0);
    check("frm_early_errs", {fe_a, pe_a, oe_a}, 3'b000);
    // Stop bit plus eight more makes exactly nine bit-times of high line.
    hold(0, 1'b1, 8 * CPB);
    send_frame(0, 8'h55, 0, 0, 1, -1);
    sb.push_back(8'h55);
    check("frm_recover_level", rd_a.level, 1);
    drain(1);

    // Fill past capacity without popping.
    for (int i = 1; i <= 10; i++) begin
      send_frame(0, 8'(8'h10 + i), 0, 0, 1, -1);
      if (i <= 8) sb.push_back(8'(8'h10 + i));
      exp_level = (i > 8) ? 8 : i;
      check($sformatf("ovr_level_%0d", i), rd_a.level, exp_level);
      check($sformatf("ovr_rts_%0d", i), rts_a, exp_level >= 6);
      check($sformatf("ovr_err_%0d", i), oe_a, i >= 9);
    end
    pulse_clr(0);
    check("ovr_clr", oe_a, 0);
    drain(8);
    @(posedge clk); #1;
    check("ovr_empty", rd_a.level, 0);
    check("ovr_rts_low", rts_a, 0);

    // Short low pulse on the idle line is a false start with no side effects.
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 2 * CPB);
    check("glitch_idle_level", rd_a.level, 0);
    check("glitch_idle_errs", {fe_a, pe_a, oe_a}, 3'b000);
    // One high sample at the centre of bit 3 is outvoted.
    send_frame(0, 8'h00, 0, 0, 1, 3);
    sb.push_back(8'h00);
    check("glitch_bit_level", rd_a.level, 1);
    check("glitch_bit_errs", {fe_a, pe_a, oe_a}, 3'b000);
    drain(1);

    // Reset mid-frame discards FIFO contents and the partial frame.
    send_frame(0, 8'h22, 0, 0, 1, -1);
    check("mid_rst_pre", rd_a.level, 1);
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_level", rd_a.level, 0);
    check("mid_rst_valid", rd_a.data_valid, 0);
    check("mid_rst_rts", rts_a, 1);
    nrst = 1'b1;
    repeat (10 * CPB) @(posedge clk);
    #1;
    send_frame(0, 8'h44, 0, 0, 1, -1);
    sb.push_back(8'h44);
    drain(1);

    check("sb_empty_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
